// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: micro-op codes
// decoded by the execute unit, default ROB tag width and entry field widths.
package alu_rs_pkg;

    localparam int DEF_TAG_W = 4;
    localparam int ORDER_W   = 6;
    localparam int DATA_W    = 32;

    // Micro-op codes shared with the execute unit decoder.
    localparam logic [ORDER_W-1:0] OP_LUI   = 6'd0;
    localparam logic [ORDER_W-1:0] OP_AUIPC = 6'd1;
    localparam logic [ORDER_W-1:0] OP_JAL   = 6'd2;
    localparam logic [ORDER_W-1:0] OP_JALR  = 6'd3;
    localparam logic [ORDER_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [ORDER_W-1:0] OP_BNE   = 6'd5;
    localparam logic [ORDER_W-1:0] OP_BLT   = 6'd6;
    localparam logic [ORDER_W-1:0] OP_BGE   = 6'd7;
    localparam logic [ORDER_W-1:0] OP_BLTU  = 6'd8;
    localparam logic [ORDER_W-1:0] OP_BGEU  = 6'd9;
    localparam logic [ORDER_W-1:0] OP_ADDI  = 6'd10;
    localparam logic [ORDER_W-1:0] OP_SLTI  = 6'd11;
    localparam logic [ORDER_W-1:0] OP_ADD   = 6'd20;
    localparam logic [ORDER_W-1:0] OP_SUB   = 6'd21;
    localparam logic [ORDER_W-1:0] OP_SLL   = 6'd22;
    localparam logic [ORDER_W-1:0] OP_SLT   = 6'd23;
    localparam logic [ORDER_W-1:0] OP_SLTU  = 6'd24;
    localparam logic [ORDER_W-1:0] OP_XOR   = 6'd25;
    localparam logic [ORDER_W-1:0] OP_OR    = 6'd28;
    localparam logic [ORDER_W-1:0] OP_AND   = 6'd29;

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index priority picker: returns the index of the lowest set request
// bit and whether any bit was set.
module alu_rs_pick
    import alu_rs_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the lowest set bit is the last to assign.
    always_comb begin
        idx   = '0;
        found = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds issued micro-ops until both operands are
// ready, snoops both CDBs, and dispatches one ready op per cycle.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    input  logic                iss_valid,
    input  logic [ORDER_W-1:0]  iss_order,
    input  logic [DATA_W-1:0]   iss_vj,
    input  logic [DATA_W-1:0]   iss_vk,
    input  logic [TAG_W-1:0]    iss_qj,
    input  logic [TAG_W-1:0]    iss_qk,
    input  logic                iss_rj_rdy,
    input  logic                iss_rk_rdy,
    input  logic [DATA_W-1:0]   iss_A,
    input  logic [DATA_W-1:0]   iss_pc,
    input  logic [TAG_W-1:0]    iss_tag,
    input  logic                cdb0_valid,
    input  logic [TAG_W-1:0]    cdb0_tag,
    input  logic [DATA_W-1:0]   cdb0_value,
    input  logic                cdb1_valid,
    input  logic [TAG_W-1:0]    cdb1_tag,
    input  logic [DATA_W-1:0]   cdb1_value,
    output logic                full,
    output logic                ex_valid,
    output logic [ORDER_W-1:0]  ex_order,
    output logic [DATA_W-1:0]   ex_vj,
    output logic [DATA_W-1:0]   ex_vk,
    output logic [DATA_W-1:0]   ex_A,
    output logic [DATA_W-1:0]   ex_pc,
    output logic [TAG_W-1:0]    ex_tag
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy_reg;
    logic [ORDER_W-1:0] order_reg [RS_SIZE];
    logic [DATA_W-1:0]  vj_reg    [RS_SIZE];
    logic [DATA_W-1:0]  vk_reg    [RS_SIZE];
    logic [TAG_W-1:0]   qj_reg    [RS_SIZE];
    logic [TAG_W-1:0]   qk_reg    [RS_SIZE];
    logic               rj_reg    [RS_SIZE];
    logic               rk_reg    [RS_SIZE];
    logic [DATA_W-1:0]  a_reg     [RS_SIZE];
    logic [DATA_W-1:0]  pc_reg    [RS_SIZE];
    logic [TAG_W-1:0]   tag_reg   [RS_SIZE];

    logic [RS_SIZE-1:0] free_req;
    logic [RS_SIZE-1:0] ready_req;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   disp_idx;
    logic               free_found;
    logic               disp_found;
    logic               issue_we;
    logic [DATA_W-1:0]  new_vj;
    logic [DATA_W-1:0]  new_vk;
    logic               new_rj;
    logic               new_rk;

    // Full, free-slot and ready searches all look at the current state only,
    // so a slot freed by this cycle's dispatch is reusable next cycle.
    assign full     = &busy_reg;
    assign free_req = ~busy_reg;
    assign issue_we = iss_valid && !full;

    generate
        for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_ready
            assign ready_req[gi] = busy_reg[gi] & rj_reg[gi] & rk_reg[gi];
        end
    endgenerate

    alu_rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_free (
        .req   (free_req),
        .idx   (free_idx),
        .found (free_found)
    );

    alu_rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_ready (
        .req   (ready_req),
        .idx   (disp_idx),
        .found (disp_found)
    );

    // Issue bypass: an unready operand whose producer broadcasts this cycle
    // is stored ready; cdb0 has priority when both buses match.
    always_comb begin
        new_vj = iss_vj;
        new_rj = iss_rj_rdy;
        new_vk = iss_vk;
        new_rk = iss_rk_rdy;
        if (!iss_rj_rdy) begin
            if (cdb0_valid && cdb0_tag == iss_qj) begin
                new_vj = cdb0_value;
                new_rj = 1'b1;
            end else if (cdb1_valid && cdb1_tag == iss_qj) begin
                new_vj = cdb1_value;
                new_rj = 1'b1;
            end
        end
        if (!iss_rk_rdy) begin
            if (cdb0_valid && cdb0_tag == iss_qk) begin
                new_vk = cdb0_value;
                new_rk = 1'b1;
            end else if (cdb1_valid && cdb1_tag == iss_qk) begin
                new_vk = cdb1_value;
                new_rk = 1'b1;
            end
        end
    end

    // Entry storage: issue into the free slot, release on dispatch, and
    // capture CDB values into waiting operands of busy entries.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_reg <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                order_reg[i] <= '0;
                vj_reg[i]    <= '0;
                vk_reg[i]    <= '0;
                qj_reg[i]    <= '0;
                qk_reg[i]    <= '0;
                rj_reg[i]    <= 1'b0;
                rk_reg[i]    <= 1'b0;
                a_reg[i]     <= '0;
                pc_reg[i]    <= '0;
                tag_reg[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                busy_reg <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (issue_we && free_found && free_idx == IDX_W'(i)) begin
                        busy_reg[i]  <= 1'b1;
                        order_reg[i] <= iss_order;
                        vj_reg[i]    <= new_vj;
                        vk_reg[i]    <= new_vk;
                        qj_reg[i]    <= iss_qj;
                        qk_reg[i]    <= iss_qk;
                        rj_reg[i]    <= new_rj;
                        rk_reg[i]    <= new_rk;
                        a_reg[i]     <= iss_A;
                        pc_reg[i]    <= iss_pc;
                        tag_reg[i]   <= iss_tag;
                    end else if (busy_reg[i]) begin
                        if (disp_found && disp_idx == IDX_W'(i)) begin
                            busy_reg[i] <= 1'b0;
                        end
                        if (!rj_reg[i]) begin
                            if (cdb0_valid && cdb0_tag == qj_reg[i]) begin
                                vj_reg[i] <= cdb0_value;
                                rj_reg[i] <= 1'b1;
                            end else if (cdb1_valid && cdb1_tag == qj_reg[i]) begin
                                vj_reg[i] <= cdb1_value;
                                rj_reg[i] <= 1'b1;
                            end
                        end
                        if (!rk_reg[i]) begin
                            if (cdb0_valid && cdb0_tag == qk_reg[i]) begin
                                vk_reg[i] <= cdb0_value;
                                rk_reg[i] <= 1'b1;
                            end else if (cdb1_valid && cdb1_tag == qk_reg[i]) begin
                                vk_reg[i] <= cdb1_value;
                                rk_reg[i] <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Dispatch register: payload holds its last value when nothing is sent.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ex_valid <= 1'b0;
            ex_order <= '0;
            ex_vj    <= '0;
            ex_vk    <= '0;
            ex_A     <= '0;
            ex_pc    <= '0;
            ex_tag   <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                ex_valid <= 1'b0;
            end else if (disp_found) begin
                ex_valid <= 1'b1;
                ex_order <= order_reg[disp_idx];
                ex_vj    <= vj_reg[disp_idx];
                ex_vk    <= vk_reg[disp_idx];
                ex_A     <= a_reg[disp_idx];
                ex_pc    <= pc_reg[disp_idx];
                ex_tag   <= tag_reg[disp_idx];
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: expected dispatches are queued when ops
// are issued and popped when ex_valid is observed.
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int RS_SIZE = 8;
    localparam int TAG_W   = 4;

    typedef struct packed {
        logic [5:0]  order;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] a;
        logic [31:0] pc;
        logic [3:0]  tag;
    } ex_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, flush_in;
    logic        iss_valid, iss_rj_rdy, iss_rk_rdy;
    logic [5:0]  iss_order;
    logic [31:0] iss_vj, iss_vk, iss_A, iss_pc;
    logic [3:0]  iss_qj, iss_qk, iss_tag;
    logic        cdb0_valid, cdb1_valid;
    logic [3:0]  cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_value, cdb1_value;
    logic        full, ex_valid;
    logic [5:0]  ex_order;
    logic [31:0] ex_vj, ex_vk, ex_A, ex_pc;
    logic [3:0]  ex_tag;

    ex_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    alu_rs #(.RS_SIZE(RS_SIZE), .TAG_W(TAG_W)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .iss_valid(iss_valid), .iss_order(iss_order), .iss_vj(iss_vj), .iss_vk(iss_vk),
        .iss_qj(iss_qj), .iss_qk(iss_qk), .iss_rj_rdy(iss_rj_rdy), .iss_rk_rdy(iss_rk_rdy),
        .iss_A(iss_A), .iss_pc(iss_pc), .iss_tag(iss_tag),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_value(cdb0_value),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_value(cdb1_value),
        .full(full), .ex_valid(ex_valid), .ex_order(ex_order), .ex_vj(ex_vj),
        .ex_vk(ex_vk), .ex_A(ex_A), .ex_pc(ex_pc), .ex_tag(ex_tag)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        iss_valid  = 1'b0;
        cdb0_valid = 1'b0;
        cdb1_valid = 1'b0;
        flush_in   = 1'b0;
    endtask

    task automatic drive_issue(input logic [5:0] order, input logic [31:0] vj, input logic [31:0] vk,
                               input logic [3:0] qj, input logic [3:0] qk, input logic rj, input logic rk,
                               input logic [31:0] a, input logic [31:0] pc, input logic [3:0] tag);
        iss_valid  = 1'b1;
        iss_order  = order;
        iss_vj     = vj;
        iss_vk     = vk;
        iss_qj     = qj;
        iss_qk     = qk;
        iss_rj_rdy = rj;
        iss_rk_rdy = rk;
        iss_A      = a;
        iss_pc     = pc;
        iss_tag    = tag;
    endtask

    function automatic ex_t mk(input logic [5:0] order, input logic [31:0] vj, input logic [31:0] vk,
                               input logic [31:0] a, input logic [31:0] pc, input logic [3:0] tag);
        ex_t e;
        e.order = order; e.vj = vj; e.vk = vk; e.a = a; e.pc = pc; e.tag = tag;
        return e;
    endfunction

    function automatic ex_t observed();
        ex_t e;
        e.order = ex_order; e.vj = ex_vj; e.vk = ex_vk; e.a = ex_A; e.pc = ex_pc; e.tag = ex_tag;
        return e;
    endfunction

    task automatic pop_exp(output ex_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        step(); step();
        rst_n_in = 1'b1;
        step();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (observed() !== ex_t'(0)) begin failures++; $display("FAIL reset_ex_fields got=%h exp=0", observed()); end
    endtask

    task automatic test_ready_add();
        ex_t e;
        drive_issue(OP_ADD, 32'd5, 32'd7, 4'd0, 4'd0, 1'b1, 1'b1, 32'h10, 32'h100, 4'd3);
        sb.push_back(mk(OP_ADD, 32'd5, 32'd7, 32'h10, 32'h100, 4'd3));
        step(); idle();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL add_early got=%b exp=0", ex_valid); end
        step();
        checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", ex_valid); end
        pop_exp(e);
        checks++; if (observed() !== e) begin failures++; $display("FAIL add_fields got=%h exp=%h", observed(), e); end
        step();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL add_after got=%b exp=0", ex_valid); end
    endtask

    task automatic test_cdb_wakeup();
        ex_t e;
        // qk matches the broadcast tag but vk is already ready and must survive.
        drive_issue(OP_SUB, 32'hDEAD, 32'd1, 4'd2, 4'd2, 1'b0, 1'b1, 32'h0, 32'h104, 4'd4);
        sb.push_back(mk(OP_SUB, 32'd10, 32'd1, 32'h0, 32'h104, 4'd4));
        step(); idle();
        step();
        cdb0_valid = 1'b1; cdb0_tag = 4'd2; cdb0_value = 32'd10;
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL wake_wait got=%b exp=0", ex_valid); end
        step(); idle();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL wake_capture_edge got=%b exp=0", ex_valid); end
        step();
        checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL wake_valid got=%b exp=1", ex_valid); end
        pop_exp(e);
        checks++; if (observed() !== e) begin failures++; $display("FAIL wake_fields got=%h exp=%h", observed(), e); end
        step();
    endtask

    task automatic test_bypass();
        ex_t e;
        drive_issue(OP_SUB, 32'h0, 32'd1, 4'd2, 4'd0, 1'b0, 1'b1, 32'h0, 32'h108, 4'd5);
        cdb0_valid = 1'b1; cdb0_tag = 4'd2; cdb0_value = 32'd20;
        cdb1_valid = 1'b1; cdb1_tag = 4'd2; cdb1_value = 32'd99;
        sb.push_back(mk(OP_SUB, 32'd20, 32'd1, 32'h0, 32'h108, 4'd5));
        step(); idle();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL bypass_early got=%b exp=0", ex_valid); end
        step();
        checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL bypass_valid got=%b exp=1", ex_valid); end
        pop_exp(e);
        checks++; if (observed() !== e) begin failures++; $display("FAIL bypass_fields got=%h exp=%h", observed(), e); end
        step();
    endtask

    task automatic test_dual_cdb();
        ex_t e;
        drive_issue(OP_SLT, 32'h0, 32'h0, 4'd4, 4'd5, 1'b0, 1'b0, 32'h0, 32'h10C, 4'd6);
        sb.push_back(mk(OP_SLT, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h10C, 4'd6));
        step(); idle();
        step();
        cdb0_valid = 1'b1; cdb0_tag = 4'd4; cdb0_value = 32'hFFFFFFFF;
        cdb1_valid = 1'b1; cdb1_tag = 4'd5; cdb1_value = 32'd1;
        step(); idle();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL dual_capture_edge got=%b exp=0", ex_valid); end
        step();
        checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL dual_valid got=%b exp=1", ex_valid); end
        pop_exp(e);
        checks++; if (observed() !== e) begin failures++; $display("FAIL dual_fields got=%h exp=%h", observed(), e); end
        step();
    endtask

    task automatic test_full_priority();
        ex_t e;
        for (int i = 0; i < RS_SIZE; i++) begin
            drive_issue(OP_ADD, 32'h0, 32'(i), 4'd9, 4'd9, 1'b0, 1'b1, 32'(i), 32'h200 + 32'(4 * i), 4'(i));
            sb.push_back(mk(OP_ADD, 32'h99, 32'(i), 32'(i), 32'h200 + 32'(4 * i), 4'(i)));
            step();
            if (i == RS_SIZE - 2) begin
                checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_one_free got=%b exp=0", full); end
            end
        end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_set got=%b exp=1", full); end
        drive_issue(OP_OR, 32'd1, 32'd2, 4'd0, 4'd0, 1'b1, 1'b1, 32'h0, 32'h300, 4'd8);
        step(); idle();
        checks++; if (full !== 1'b1 || ex_valid !== 1'b0) begin failures++; $display("FAIL full_drop got full=%b ex_valid=%b exp full=1 ex_valid=0", full, ex_valid); end
        cdb1_valid = 1'b1; cdb1_tag = 4'd9; cdb1_value = 32'h99;
        step(); idle();
        for (int i = 0; i < RS_SIZE; i++) begin
            step();
            checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL prio_valid idx=%0d got=%b exp=1", i, ex_valid); end
            pop_exp(e);
            checks++; if (observed() !== e) begin failures++; $display("FAIL prio_fields idx=%0d got=%h exp=%h", i, observed(), e); end
            checks++; if (full !== 1'b0) begin failures++; $display("FAIL prio_full idx=%0d got=%b exp=0", i, full); end
        end
        step();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL prio_drained got=%b exp=0", ex_valid); end
    endtask

    task automatic test_back_to_back();
        ex_t e;
        drive_issue(OP_XOR, 32'hA, 32'hB, 4'd0, 4'd0, 1'b1, 1'b1, 32'h1, 32'h400, 4'd10);
        sb.push_back(mk(OP_XOR, 32'hA, 32'hB, 32'h1, 32'h400, 4'd10));
        step();
        drive_issue(OP_AND, 32'hC, 32'hD, 4'd0, 4'd0, 1'b1, 1'b1, 32'h2, 32'h404, 4'd11);
        sb.push_back(mk(OP_AND, 32'hC, 32'hD, 32'h2, 32'h404, 4'd11));
        step(); idle();
        for (int i = 0; i < 2; i++) begin
            checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid n=%0d got=%b exp=1", i, ex_valid); end
            pop_exp(e);
            checks++; if (observed() !== e) begin failures++; $display("FAIL b2b_fields n=%0d got=%h exp=%h", i, observed(), e); end
            step();
        end
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL b2b_after got=%b exp=0", ex_valid); end
    endtask

    task automatic test_flush();
        drive_issue(OP_ADD, 32'h0, 32'h0, 4'd9, 4'd9, 1'b0, 1'b0, 32'h0, 32'h500, 4'd1);
        step();
        drive_issue(OP_ADD, 32'h0, 32'h0, 4'd9, 4'd9, 1'b0, 1'b0, 32'h0, 32'h504, 4'd2);
        step();
        drive_issue(OP_ADD, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 32'h0, 32'h508, 4'd3);
        step();
        // A ready entry exists now; flush must beat its dispatch and the new issue.
        drive_issue(OP_ADD, 32'd2, 32'd2, 4'd0, 4'd0, 1'b1, 1'b1, 32'h0, 32'h50C, 4'd4);
        flush_in = 1'b1;
        step(); idle();
        checks++; if (ex_valid !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL flush_edge got ex_valid=%b full=%b exp 0 0", ex_valid, full); end
        cdb0_valid = 1'b1; cdb0_tag = 4'd9; cdb0_value = 32'h1;
        step(); idle();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_empty n=%0d got=%b exp=0", i, ex_valid); end
        end
    endtask

    task automatic test_freeze();
        ex_t e;
        drive_issue(OP_SLL, 32'h3, 32'h4, 4'd0, 4'd0, 1'b1, 1'b1, 32'h5, 32'h600, 4'd12);
        sb.push_back(mk(OP_SLL, 32'h3, 32'h4, 32'h5, 32'h600, 4'd12));
        step();
        rdy_in = 1'b0;
        drive_issue(OP_SLTU, 32'h7, 32'h8, 4'd0, 4'd0, 1'b1, 1'b1, 32'h0, 32'h604, 4'd13);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL freeze_hold n=%0d got=%b exp=0", i, ex_valid); end
        end
        rdy_in = 1'b1; idle();
        step();
        checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL freeze_release got=%b exp=1", ex_valid); end
        pop_exp(e);
        checks++; if (observed() !== e) begin failures++; $display("FAIL freeze_fields got=%h exp=%h", observed(), e); end
        rdy_in = 1'b0;
        step();
        checks++; if (ex_valid !== 1'b1 || observed() !== e) begin failures++; $display("FAIL freeze_out_hold got v=%b %h exp v=1 %h", ex_valid, observed(), e); end
        rdy_in = 1'b1;
        step();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL freeze_issue_dropped got=%b exp=0", ex_valid); end
    endtask

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        iss_valid = 1'b0; iss_order = '0; iss_vj = '0; iss_vk = '0; iss_qj = '0; iss_qk = '0;
        iss_rj_rdy = 1'b0; iss_rk_rdy = 1'b0; iss_A = '0; iss_pc = '0; iss_tag = '0;
        cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_value = '0;
        cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_value = '0;
        test_reset();
        test_ready_add();
        test_cdb_wakeup();
        test_bypass();
        test_dual_cdb();
        test_full_priority();
        test_back_to_back();
        test_flush();
        test_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station for the ALU path of the Tomasulo core.
- Buffers issued ALU/branch/jump micro-ops until both operands are ready.
- Snoops both CDBs to capture forwarded values.
- Dispatches one ready micro-op per cycle as registered order/vj/vk/A/pc to the combinational execute unit, with the ROB tag kept alongside for CDB broadcast.

Parameters:
- RS_SIZE, 8, number of entries (power of two, 2..16).
- TAG_W, 4, ROB tag width.

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; low = freeze all state
- flush_in  in  1  branch mispredict; clear all entries
- iss_valid  in  1  issue request this cycle
- iss_order  in  6  micro-op code
- iss_vj / iss_vk  in  32  operand values, valid when the matching rdy is 1
- iss_qj / iss_qk  in  TAG_W  producing ROB tag, used when the matching rdy is 0
- iss_rj_rdy / iss_rk_rdy  in  1  operand already available
- iss_A  in  32  immediate
- iss_pc  in  32  instruction pc
- iss_tag  in  TAG_W  destination ROB tag
- cdb0_valid, cdb0_tag, cdb0_value  in  1/TAG_W/32  ALU result bus
- cdb1_valid, cdb1_tag, cdb1_value  in  1/TAG_W/32  load/store result bus
- full  out  1  no free entry (combinational from current state)
- ex_valid  out  1  dispatch valid
- ex_order  out  6  to execute unit
- ex_vj / ex_vk / ex_A / ex_pc  out  32  to execute unit
- ex_tag  out  TAG_W  ROB tag of the dispatched op

Behaviour:
- Reset (async, rst_n_in=0): all entry busy bits 0; ex_valid=0; ex_order=0; ex_vj=ex_vk=ex_A=ex_pc=0; ex_tag=0; full=0.
- Freeze: rdy_in=0 holds every register, outputs included; issue and CDB inputs are ignored that cycle.
- Precedence: rdy_in=0 beats flush_in; flush_in beats issue, dispatch and capture.
- Flush: all busy bits clear; ex_valid=0 on the next edge; any iss_valid in the same cycle is dropped.
- Issue, normal case:
  - If iss_valid and not full, write the lowest-index non-busy entry and set its busy bit.
  - The issuer must not assert iss_valid while full=1; if it does, the request is dropped and the state is unchanged.
- Issue bypass: an operand with rdy=0 whose q matches a valid CDB tag in the same cycle is stored ready, with the CDB value. If both CDBs match, cdb0 wins.
- Capture: every busy entry with an unready operand whose q equals a valid CDB tag latches the value and marks the operand ready. Both operands may capture in one cycle, from the same or different buses.
- Dispatch:
  - Each active cycle, select the lowest-index busy entry with both operands ready in the current state.
  - Values captured this cycle do not qualify until the next cycle.
  - On the edge: ex_* take that entry's fields, ex_valid=1, and the entry's busy bit clears.
  - If no entry qualifies: ex_valid=0; the other ex_* hold their previous values.
- Latency:
  - Issue with both operands ready at cycle N: ex_valid=1 after edge N+1 (the op is in the entry after edge N and dispatched at edge N+1).
  - Operand woken by the CDB at cycle N: dispatched at edge N+1 at the earliest.
- Same-cycle dispatch and issue: the slot freed by dispatch is not visible to issue until the next cycle, because full and the free-slot search use the current state.
- Occupancy:
  - full=1 iff all RS_SIZE busy bits are 1.
  - With one entry free, an issue is accepted and full rises after that edge.
- Tag compare: a CDB compare uses the full TAG_W bits and applies only to unready operands. A ready operand is never overwritten.

Decomposition:
- Shared package (or the existing define header):
  - micro-op codes (the same 6-bit constants the execute unit decodes, e.g. LUI, ADD, BEQ, JALR);
  - TAG_W;
  - RS entry field widths.
- Sub-module alu_rs_pick: combinational lowest-index priority picker, used twice (free-slot search and ready-entry search). It has an RS_SIZE-bit request input and outputs an index plus a found flag.

Test Plan:
- Reset/idle: hold rst_n_in=0, then release with no issue -> ex_valid=0, full=0, all ex_* = 0.
- Ready ADD: issue ADD vj=5, vk=7, both rdy, tag=3 at cycle N -> edge N+1: ex_valid=1, ex_order=ADD, ex_vj=5, ex_vk=7, ex_tag=3; ex_valid=0 on the following cycle.
- CDB wakeup and bypass:
  - Issue SUB with qj=2 unready, vk=1 ready; cdb0 tag=2 value=10 two cycles later -> dispatch one edge after the broadcast with ex_vj=10.
  - Repeat with the broadcast in the same cycle as the issue -> dispatch at edge N+1.
- Dual CDB: issue SLT with qj=4, qk=5, both unready; cdb0 tag=4 value=0xFFFFFFFF and cdb1 tag=5 value=1 in the same cycle -> both captured, dispatched next edge with ex_vj=0xFFFFFFFF, ex_vk=1.
- Full and priority:
  - Issue 8 ops, all waiting on tag 9 -> full=1; a 9th iss_valid is dropped.
  - Broadcast tag 9 -> entries dispatch in index order 0..7 on consecutive cycles; full=0 after the first dispatch.
- Flush and freeze:
  - With 3 busy entries, assert flush_in together with iss_valid -> all entries empty, ex_valid=0, the issued op is lost.
  - Drive rdy_in=0 with a ready entry -> no dispatch until rdy_in returns to 1.
